// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller: evaluates branch conditions, forms targets,
// emits link data, fetch redirects and misalignment exceptions, and keeps taken statistics.
module branch_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_kind,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_pc,
  input  logic [31:0]          req_rs1,
  input  logic [31:0]          req_rs2,
  input  logic [31:0]          req_imm,
  output logic                 redir_valid,
  input  logic                 redir_ready,
  output logic [31:0]          redir_pc,
  output logic                 link_valid,
  output logic [31:0]          link_data,
  output logic                 misalign_exc,
  output logic                 done,
  input  logic                 kill,
  output logic [CNT_WIDTH-1:0] taken_cnt,
  output logic [CNT_WIDTH-1:0] ntaken_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EVAL     = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;
  localparam logic [1:0] EXC      = 2'd3;

  logic [1:0]  state;
  logic [1:0]  kind_p0;
  logic [31:0] pc_p0;
  logic [31:0] rs1_p0;
  logic [31:0] imm_p0;
  logic        taken_p0;
  logic        accept;
  logic        acc_taken;
  logic        acc_link;
  logic [31:0] target_p1;
  logic        misal_p1;

  function automatic logic cond_taken(input logic [1:0] kind, input logic [2:0] funct3,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    logic t;
    t = 1'b0;
    case (kind)
      2'd0: begin
        case (funct3)
          3'd0:    t = (rs1 == rs2);
          3'd1:    t = (rs1 != rs2);
          3'd4:    t = ($signed(rs1) <  $signed(rs2));
          3'd5:    t = ($signed(rs1) >= $signed(rs2));
          3'd6:    t = (rs1 <  rs2);
          3'd7:    t = (rs1 >= rs2);
          default: t = 1'b0;
        endcase
      end
      2'd1, 2'd2: t = 1'b1;
      default:    t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE) && !kill;
  // The condition is resolved as the request is captured so a not-taken done can be
  // presented from a register during the single EVAL cycle.
  assign acc_taken = cond_taken(req_kind, req_funct3, req_rs1, req_rs2);
  assign acc_link  = (req_kind == 2'd1) || (req_kind == 2'd2);

  assign target_p1 = (kind_p0 == 2'd2) ? ((rs1_p0 + imm_p0) & 32'hFFFF_FFFE)
                                       : (pc_p0 + imm_p0);
  assign misal_p1  = |target_p1[1:0];

  // Stage p0: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_p0  <= req_kind;
      pc_p0    <= req_pc;
      rs1_p0   <= req_rs1;
      imm_p0   <= req_imm;
      taken_p0 <= acc_taken;
    end
  end

  // Stage p1: control FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      redir_valid  <= 1'b0;
      redir_pc     <= '0;
      link_valid   <= 1'b0;
      link_data    <= '0;
      misalign_exc <= 1'b0;
      done         <= 1'b0;
      taken_cnt    <= '0;
      ntaken_cnt   <= '0;
    end else begin
      link_valid   <= 1'b0;
      misalign_exc <= 1'b0;
      done         <= 1'b0;
      if (kill) begin
        state       <= IDLE;
        redir_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              state      <= EVAL;
              done       <= !acc_taken;
              link_valid <= acc_link;
              link_data  <= req_pc + 32'd4;
            end
          end
          EVAL: begin
            if (kind_p0 == 2'd0) begin
              if (taken_p0) taken_cnt  <= sat_inc(taken_cnt);
              else          ntaken_cnt <= sat_inc(ntaken_cnt);
            end
            if (taken_p0 && misal_p1) begin
              state        <= EXC;
              misalign_exc <= 1'b1;
              done         <= 1'b1;
            end else if (taken_p0) begin
              state       <= REDIRECT;
              redir_valid <= 1'b1;
              redir_pc    <= target_p1;
            end else begin
              state <= IDLE;
            end
          end
          REDIRECT: begin
            if (redir_ready) begin
              state       <= IDLE;
              redir_valid <= 1'b0;
              done        <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
